if_fetch_queue: RTL and testbench

- Instruction fetch stage: the producer of the 32-bit instruction word and PC+4 that the decode/register-read stage consumes.
- Holds the fetch PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned words in a small FIFO and presents them to decode over a valid/ready handshake.
- Supports redirect (branch/jump/jal target from execute) with queue flush and in-flight request drain.

---
 rtl/if_fetch_queue_if.sv | 27 ++
 rtl/if_fetch_queue.sv | 145 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus bundle: imem request/response, decode handshake,
// redirect input and the sticky error flag.
interface if_fetch_queue_if;
  logic        Ireq;
  logic [31:0] Iadr;
  logic        Iack;
  logic [31:0] Irdata;
  logic [31:0] Ins;
  logic [31:0] Pc4;
  logic        Ivalid;
  logic        Iready;
  logic        Redir;
  logic [31:0] RedirAdr;
  logic        Err;

  // Fetch unit side
  modport master (
    output Ireq, Iadr, Ins, Pc4, Ivalid, Err,
    input  Iack, Irdata, Iready, Redir, RedirAdr
  );

  // Environment side (imem + decode + execute)
  modport slave (
    input  Ireq, Iadr, Ins, Pc4, Ivalid, Err,
    output Iack, Irdata, Iready, Redir, RedirAdr
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: one outstanding imem request at a time, a small
// FIFO of {instruction, PC+4} toward decode, and redirect with flush/drain.
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               CLK,
  input logic               RST,
  if_fetch_queue_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   adr_q, adr_d;
  logic          req_q, req_d;
  logic          err_q, err_d;
  logic          halt_pend_q, halt_pend_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic [31:0]   ins_mem [DEPTH];
  logic [31:0]   pc4_mem [DEPTH];

  logic          push;
  logic          pop;
  logic          valid;
  logic          misal;
  logic          drain_to_halt;

  assign valid         = (cnt_q != '0);
  assign misal         = (bus.RedirAdr[1:0] != 2'b00);
  assign drain_to_halt = halt_pend_q || (bus.Redir && misal);

  // Next-state logic: request launch/accept, queue bookkeeping, redirect handling
  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    adr_d       = adr_q;
    req_d       = req_q;
    err_d       = err_q;
    halt_pend_d = halt_pend_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    push        = 1'b0;
    pop         = 1'b0;
    case (state_q)
      FETCH: begin
        if (bus.Redir) begin
          // Redirect wins over push and pop: the queue is simply emptied
          wr_d  = '0;
          rd_d  = '0;
          cnt_d = '0;
          if (misal) err_d = 1'b1;
          else       fpc_d = bus.RedirAdr;
          if (req_q && !bus.Iack) begin
            // Request still in flight: keep it on the bus until imem accepts
            state_d     = DRAIN;
            halt_pend_d = misal;
          end else begin
            // Nothing in flight, or its data returns now and is dropped
            req_d   = 1'b0;
            state_d = misal ? HALT : FETCH;
          end
        end else begin
          push = req_q && bus.Iack;
          pop  = valid && bus.Iready;
          if (push) begin
            req_d = 1'b0;
            fpc_d = adr_q + 32'd4;
            wr_d  = wr_q + AW'(1);
          end else if (!req_q && (cnt_q < FULL)) begin
            req_d = 1'b1;
            adr_d = fpc_q;
          end
          if (pop) rd_d = rd_q + AW'(1);
          if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
          else if (!push && pop) cnt_d = cnt_q - (AW+1)'(1);
        end
      end
      DRAIN: begin
        if (bus.Redir) begin
          if (misal) begin
            err_d       = 1'b1;
            halt_pend_d = 1'b1;
          end else begin
            fpc_d = bus.RedirAdr;
          end
        end
        if (bus.Iack) begin
          req_d   = 1'b0;
          state_d = drain_to_halt ? HALT : FETCH;
        end
      end
      default: begin
        // HALT: frozen until reset
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= FETCH;
      fpc_q       <= RESET_PC;
      adr_q       <= '0;
      req_q       <= 1'b0;
      err_q       <= 1'b0;
      halt_pend_q <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      adr_q       <= adr_d;
      req_q       <= req_d;
      err_q       <= err_d;
      halt_pend_q <= halt_pend_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
    end
  end

  // Queue storage: word and its link value written at the write pointer
  always_ff @(posedge CLK) begin
    if (push) begin
      ins_mem[wr_q] <= bus.Irdata;
      pc4_mem[wr_q] <= adr_q + 32'd4;
    end
  end

  assign bus.Ireq   = req_q;
  assign bus.Iadr   = adr_q;
  assign bus.Ivalid = valid;
  assign bus.Ins    = valid ? ins_mem[rd_q] : '0;
  assign bus.Pc4    = valid ? pc4_mem[rd_q] : '0;
  assign bus.Err    = err_q;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: imem responder, queue-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_if_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int RUN = 0, DRN = 1, HLT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_queue_if bus();

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int fails  = 0;
  int ack_delay = 1;

  logic [31:0] acc_log[$];
  logic [63:0] pop_log[$];

  // Reference model state
  logic [63:0] m_q[$];
  logic [31:0] m_fpc, m_adr;
  logic        m_pend, m_err, m_halt_after;
  logic        m_live = 1'b0;
  int          m_mode;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h0108_4820;
    return {a[15:0], 16'hA5A5} ^ 32'h1357_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timeout", name);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_ireq(input string name);
    int n = 0;
    while (!bus.Ireq && n < 40) begin step(); n++; end
    if (!bus.Ireq) timeout(name);
  endtask

  task automatic wait_iack(input string name);
    int n = 0;
    while (!(bus.Ireq && bus.Iack) && n < 40) begin step(); n++; end
    if (!(bus.Ireq && bus.Iack)) timeout(name);
  endtask

  task automatic wait_acc(input int cnt, input string name);
    int n = 0;
    while (acc_log.size() < cnt && n < 60) begin step(); n++; end
    if (acc_log.size() < cnt) timeout(name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.Redir = 1'b0;
    step(2);
    rst = 1'b0;
    acc_log.delete();
    pop_log.delete();
  endtask

  function automatic logic saw_pc4(input logic [31:0] v);
    foreach (pop_log[i]) if (pop_log[i][31:0] == v) return 1'b1;
    return 1'b0;
  endfunction

  // imem: accept after ack_delay cycles of a held request
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    bus.Iack   = 1'b0;
    bus.Irdata = '0;
    forever begin
      @(negedge clk);
      if (bus.Ireq) begin
        if (wait_cnt >= ack_delay) begin
          bus.Iack   = 1'b1;
          bus.Irdata = mem_word(bus.Iadr);
        end else begin
          bus.Iack = 1'b0;
        end
        wait_cnt++;
      end else begin
        bus.Iack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Transaction recorder: accepted imem addresses and words consumed by decode
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.Ireq && bus.Iack) acc_log.push_back(bus.Iadr);
      if (bus.Ivalid && bus.Iready && !bus.Redir) pop_log.push_back({bus.Ins, bus.Pc4});
    end
  end

  // Reference model: advanced on each rising edge from the sampled inputs
  always @(posedge clk) begin
    logic mis, ack;
    int   sz;
    if (rst) begin
      m_q.delete();
      m_fpc = RESET_PC; m_adr = '0; m_pend = 1'b0; m_err = 1'b0;
      m_halt_after = 1'b0; m_mode = RUN; m_live = 1'b1;
    end else if (m_live && m_mode != HLT) begin
      mis = (bus.RedirAdr[1:0] != 2'b00);
      ack = m_pend && bus.Iack;
      if (m_mode == DRN) begin
        if (bus.Redir) begin
          if (mis) begin m_err = 1'b1; m_halt_after = 1'b1; end
          else m_fpc = bus.RedirAdr;
        end
        if (ack) begin
          m_pend = 1'b0;
          m_mode = m_halt_after ? HLT : RUN;
        end
      end else if (bus.Redir) begin
        m_q.delete();
        if (mis) m_err = 1'b1;
        else     m_fpc = bus.RedirAdr;
        if (m_pend && !bus.Iack) begin
          m_mode = DRN;
          m_halt_after = mis;
        end else begin
          m_pend = 1'b0;
          m_mode = mis ? HLT : RUN;
        end
      end else begin
        sz = m_q.size();
        if (sz != 0 && bus.Iready) void'(m_q.pop_front());
        if (ack) begin
          m_q.push_back({bus.Irdata, m_adr + 32'd4});
          m_fpc  = m_adr + 32'd4;
          m_pend = 1'b0;
        end else if (!m_pend && sz < DEPTH) begin
          m_pend = 1'b1;
          m_adr  = m_fpc;
        end
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  always @(posedge clk) begin
    #1;
    if (m_live) begin
      check("Ireq", 32'(bus.Ireq), 32'(m_pend));
      check("Iadr", bus.Iadr, m_adr);
      check("Ivalid", 32'(bus.Ivalid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check("Ins", bus.Ins, m_q[0][63:32]);
        check("Pc4", bus.Pc4, m_q[0][31:0]);
      end
      check("Err", 32'(bus.Err), 32'(m_err));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.Iready   = 1'b0;
    bus.Redir    = 1'b0;
    bus.RedirAdr = '0;

    // Reset then streaming
    ack_delay  = 1;
    bus.Iready = 1'b1;
    rst = 1'b1;
    step(2);
    check("rst Ireq",   32'(bus.Ireq),   32'd0);
    check("rst Ivalid", 32'(bus.Ivalid), 32'd0);
    check("rst Iadr",   bus.Iadr,        32'd0);
    check("rst Ins",    bus.Ins,         32'd0);
    check("rst Pc4",    bus.Pc4,         32'd0);
    check("rst Err",    32'(bus.Err),    32'd0);
    rst = 1'b0;
    acc_log.delete();
    pop_log.delete();
    step(14);
    check("s1 pops", 32'(pop_log.size() >= 2), 32'd1);
    check("s1 accs", 32'(acc_log.size() >= 3), 32'd1);
    if (pop_log.size() >= 2 && acc_log.size() >= 3) begin
      check("s1 ins0", pop_log[0][63:32], 32'h2008_0005);
      check("s1 pc40", pop_log[0][31:0],  32'h0000_0004);
      check("s1 ins1", pop_log[1][63:32], 32'h0108_4820);
      check("s1 pc41", pop_log[1][31:0],  32'h0000_0008);
      check("s1 adr0", acc_log[0], 32'h0);
      check("s1 adr1", acc_log[1], 32'h4);
      check("s1 adr2", acc_log[2], 32'h8);
    end
    $display("scenario streaming done: %0d words accepted", acc_log.size());

    // Backpressure / full
    ack_delay  = 0;
    bus.Iready = 1'b0;
    do_reset();
    step(14);
    check("s2 four accepted", 32'(acc_log.size()), 32'd4);
    check("s2 full Ireq", 32'(bus.Ireq), 32'd0);
    step(3);
    check("s2 full Ireq hold", 32'(bus.Ireq), 32'd0);
    bus.Iready = 1'b1;
    step();
    bus.Iready = 1'b0;
    check("s2 one pop", 32'(pop_log.size()), 32'd1);
    wait_ireq("s2 refill Ireq");
    check("s2 refill Iadr", bus.Iadr, 32'h10);
    if (pop_log.size() == 1) check("s2 pop pc4", pop_log[0][31:0], 32'h4);
    $display("scenario backpressure done: refill Iadr=%h", bus.Iadr);

    // Redirect while idle with two entries queued
    do_reset();
    wait_acc(2, "s3 two words");
    check("s3 idle Ireq", 32'(bus.Ireq), 32'd0);
    bus.Redir = 1'b1; bus.RedirAdr = 32'h40;
    step();
    bus.Redir = 1'b0;
    check("s3 flushed Ivalid", 32'(bus.Ivalid), 32'd0);
    pop_log.delete();
    wait_ireq("s3 Ireq");
    check("s3 Iadr", bus.Iadr, 32'h40);
    bus.Iready = 1'b1;
    step(6);
    bus.Iready = 1'b0;
    check("s3 pops", 32'(pop_log.size() >= 1), 32'd1);
    if (pop_log.size() >= 1) begin
      check("s3 first Pc4", pop_log[0][31:0], 32'h44);
      check("s3 first Ins", pop_log[0][63:32], mem_word(32'h40));
    end
    $display("scenario redirect idle done");

    // Redirect with a request in flight
    bus.Iready = 1'b1;
    do_reset();
    wait_acc(2, "s4 two words");
    ack_delay = 3;
    wait_ireq("s4 Ireq");
    check("s4 pending Iadr", bus.Iadr, 32'h8);
    bus.Redir = 1'b1; bus.RedirAdr = 32'h100;
    step();
    bus.Redir = 1'b0;
    wait_iack("s4 Iack");
    check("s4 held Iadr", bus.Iadr, 32'h8);
    step();
    ack_delay = 0;
    wait_ireq("s4 new Ireq");
    check("s4 new Iadr", bus.Iadr, 32'h100);
    step(8);
    check("s4 drained word absent", 32'(saw_pc4(32'hC)), 32'd0);
    check("s4 target consumed", 32'(saw_pc4(32'h104)), 32'd1);
    $display("scenario redirect mid-request done");

    // Redirect, Iack and pop in the same cycle
    bus.Iready = 1'b0;
    do_reset();
    wait_acc(2, "s5 two words");
    ack_delay = 2;
    wait_iack("s5 Iack");
    check("s5 acked Iadr", bus.Iadr, 32'h8);
    check("s5 queue nonempty", 32'(bus.Ivalid), 32'd1);
    bus.Redir = 1'b1; bus.RedirAdr = 32'h300; bus.Iready = 1'b1;
    step();
    bus.Redir = 1'b0; bus.Iready = 1'b0;
    check("s5 flushed Ivalid", 32'(bus.Ivalid), 32'd0);
    pop_log.delete();
    ack_delay = 0;
    wait_ireq("s5 Ireq");
    check("s5 Iadr", bus.Iadr, 32'h300);
    bus.Iready = 1'b1;
    step(6);
    bus.Iready = 1'b0;
    check("s5 discarded absent", 32'(saw_pc4(32'hC)), 32'd0);
    if (pop_log.size() >= 1) check("s5 first Pc4", pop_log[0][31:0], 32'h304);
    else timeout("s5 first pop");
    $display("scenario simultaneous redirect done");

    // Misaligned redirect, halt, reset recovery
    bus.Iready = 1'b1;
    do_reset();
    step(5);
    bus.Redir = 1'b1; bus.RedirAdr = 32'h102;
    step();
    bus.Redir = 1'b0;
    step(4);
    check("s6 Err", 32'(bus.Err), 32'd1);
    check("s6 Ireq", 32'(bus.Ireq), 32'd0);
    check("s6 Ivalid", 32'(bus.Ivalid), 32'd0);
    acc_log.delete();
    bus.Redir = 1'b1; bus.RedirAdr = 32'h200;
    step();
    bus.Redir = 1'b0;
    step(6);
    check("s6 halt Ireq", 32'(bus.Ireq), 32'd0);
    check("s6 halt no fetch", 32'(acc_log.size()), 32'd0);
    check("s6 halt Err", 32'(bus.Err), 32'd1);
    rst = 1'b1;
    step();
    check("s6 reset Err", 32'(bus.Err), 32'd0);
    rst = 1'b0;
    acc_log.delete();
    wait_acc(1, "s6 restart");
    if (acc_log.size() >= 1) check("s6 restart Iadr", acc_log[0], RESET_PC);
    $display("scenario misaligned/halt/reset done");

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
